// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the shared ALU operand-2 mux,
// register/PC write strobes and memory handshakes; bus timeouts and illegal opcodes land in a sticky TRAP.
module riscv_multicycle_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic [2:0] op2_sel,
  output logic       rf_we,
  output logic       wb_mem,
  output logic       pc_we,
  output logic       pc_jump,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [2:0] OP2_RS2 = 3'd0;
  localparam logic [2:0] OP2_IMI = 3'd1;
  localparam logic [2:0] OP2_IMS = 3'd2;
  localparam logic [2:0] OP2_IMJ = 3'd3;
  localparam logic [2:0] OP2_IMU = 3'd4;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  // Last waiting cycle before a missing ack becomes a trap.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_OP,
    C_BRANCH,
    C_OPIMM,
    C_LOAD,
    C_JALR,
    C_STORE,
    C_JAL,
    C_LUI,
    C_AUIPC
  } class_t;

  state_t          state, state_next;
  class_t          cls, cls_next;
  class_t          dec_cls;
  logic [2:0]      op2_q, op2_next, dec_sel;
  logic            dec_legal;
  logic [1:0]      cause_q, cause_next;
  logic [TO_W-1:0] to_cnt, to_cnt_next;
  logic            waiting, expired;

  always_comb begin
    dec_cls   = C_OP;
    dec_sel   = OP2_RS2;
    dec_legal = 1'b1;
    case (opcode)
      7'b0110011: begin dec_cls = C_OP;     dec_sel = OP2_RS2; end
      7'b1100011: begin dec_cls = C_BRANCH; dec_sel = OP2_RS2; end
      7'b0010011: begin dec_cls = C_OPIMM;  dec_sel = OP2_IMI; end
      7'b0000011: begin dec_cls = C_LOAD;   dec_sel = OP2_IMI; end
      7'b1100111: begin dec_cls = C_JALR;   dec_sel = OP2_IMI; end
      7'b0100011: begin dec_cls = C_STORE;  dec_sel = OP2_IMS; end
      7'b1101111: begin dec_cls = C_JAL;    dec_sel = OP2_IMJ; end
      7'b0110111: begin dec_cls = C_LUI;    dec_sel = OP2_IMU; end
      7'b0010111: begin dec_cls = C_AUIPC;  dec_sel = OP2_IMU; end
      default:    dec_legal = 1'b0;
    endcase
  end

  // An ack in the limit cycle takes priority: expired is only raised while still waiting.
  assign waiting = ((state == S_FETCH) && !imem_ack) || ((state == S_MEM) && !dmem_ack);
  assign expired = waiting && (to_cnt >= TO_LAST);

  always_comb begin
    state_next = state;
    cls_next   = cls;
    op2_next   = op2_q;
    cause_next = cause_q;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          state_next = S_DECODE;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_next = S_EXEC;
          cls_next   = dec_cls;
          op2_next   = dec_sel;
        end else begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: state_next = S_MEM;
          C_BRANCH:        state_next = S_FETCH;
          default:         state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_next = (cls == C_STORE) ? S_FETCH : S_WB;
        end else if (expired) begin
          state_next = S_TRAP;
          cause_next = CAUSE_DMEM_TO;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    if (state_next != state) begin
      to_cnt_next = '0;
    end else if (waiting && (to_cnt != {TO_W{1'b1}})) begin
      to_cnt_next = to_cnt + 1'b1;
    end else begin
      to_cnt_next = to_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      cls     <= C_OP;
      op2_q   <= OP2_RS2;
      cause_q <= 2'd0;
      to_cnt  <= '0;
    end else begin
      state   <= state_next;
      cls     <= cls_next;
      op2_q   <= op2_next;
      cause_q <= cause_next;
      to_cnt  <= to_cnt_next;
    end
  end

  // Strobes are gated by rst_n so nothing is driven while reset is held.
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    rf_we    = 1'b0;
    wb_mem   = 1'b0;
    pc_we    = 1'b0;
    pc_jump  = 1'b0;
    trap     = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ack;
        end
        S_EXEC: begin
          if (cls == C_BRANCH) begin
            pc_we   = 1'b1;
            pc_jump = branch_taken;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls == C_STORE);
          pc_we    = (cls == C_STORE) && dmem_ack;
        end
        S_WB: begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          wb_mem  = (cls == C_LOAD);
          pc_jump = (cls == C_JAL) || (cls == C_JALR);
        end
        S_TRAP:  trap = 1'b1;
        default: trap = 1'b0;
      endcase
    end
  end

  assign op2_sel    = op2_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed plus randomized instruction streams checked cycle by cycle against an instruction-level model.
module tb_riscv_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [2:0] RS2 = 3'd0;
  localparam logic [2:0] IMI = 3'd1;
  localparam logic [2:0] IMS = 3'd2;
  localparam logic [2:0] IMJ = 3'd3;
  localparam logic [2:0] IMU = 3'd4;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_we;
    logic [2:0] op2_sel;
    logic       rf_we;
    logic       wb_mem;
    logic       pc_we;
    logic       pc_jump;
    logic       trap;
    logic [1:0] trap_cause;
  } outv_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_taken, imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_we;
  logic [2:0] op2_sel;
  logic       rf_we, wb_mem, pc_we, pc_jump, trap;
  logic [1:0] trap_cause;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         pcwe_cnt;
  logic [2:0] cur_op2;
  logic [6:0] legal_ops [9];

  always #5 clk = ~clk;

  riscv_multicycle_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .ir_we(ir_we), .op2_sel(op2_sel), .rf_we(rf_we), .wb_mem(wb_mem),
    .pc_we(pc_we), .pc_jump(pc_jump), .trap(trap), .trap_cause(trap_cause)
  );

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outv_t observed();
    outv_t o;
    o = {imem_req, dmem_req, dmem_we, ir_we, op2_sel, rf_we, wb_mem, pc_we, pc_jump, trap, trap_cause};
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at posedge+1: drive inputs, check at the falling edge, advance one cycle.
  task automatic step(input logic ia, input logic da, input logic bt, input outv_t e,
                      input bit mask_op2, input string tag);
    outv_t o;
    imem_ack = ia;
    dmem_ack = da;
    branch_taken = bt;
    @(negedge clk);
    o = observed();
    if (mask_op2) begin
      o.op2_sel = '0;
      e.op2_sel = '0;
    end
    chk(tag, 32'(o), 32'(e));
    if (pc_we) pcwe_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic trap_tail(input logic [1:0] cause);
    outv_t e;
    for (int i = 0; i < 3; i++) begin
      e = '0;
      e.trap = 1'b1;
      e.trap_cause = cause;
      step(rb(), rb(), rb(), e, 1'b1, "trap_hold");
    end
    chk("trap_no_pc_we", 32'(pcwe_cnt), 32'd0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk("reset_async", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_hold", 32'(observed()), 32'd0);
    rst_n = 1'b1;
    cur_op2 = RS2;
  endtask

  // Instruction-level reference: di/dd = cycles waited before the ack (>= TO means never).
  task automatic do_instr(input logic [6:0] op, input int di, input int dd, input logic bt,
                          output int cycles, output bit trapped);
    outv_t e;
    logic [2:0] sel;
    bit legal, ld, st, br, jmp, done;
    legal = 1; sel = RS2; ld = 0; st = 0; br = 0; jmp = 0;
    case (op)
      OPC_OP:           sel = RS2;
      OPC_BR:           br = 1;
      OPC_IMM:          sel = IMI;
      OPC_LOAD:         begin sel = IMI; ld = 1; end
      OPC_JALR:         begin sel = IMI; jmp = 1; end
      OPC_STORE:        begin sel = IMS; st = 1; end
      OPC_JAL:          begin sel = IMJ; jmp = 1; end
      OPC_LUI, OPC_AUIPC: sel = IMU;
      default:          legal = 0;
    endcase
    opcode = op;
    cycles = 0;
    pcwe_cnt = 0;
    trapped = 0;
    done = 0;
    for (int c = 0; c < TO; c++) begin
      e = '0;
      e.op2_sel = cur_op2;
      e.imem_req = 1'b1;
      e.ir_we = (c == di);
      step(c == di, rb(), rb(), e, 1'b0, "fetch");
      cycles++;
      if (c == di) break;
    end
    if (di >= TO) begin
      trap_tail(2'd2);
      trapped = 1;
      return;
    end
    e = '0;
    e.op2_sel = cur_op2;
    step(rb(), rb(), rb(), e, 1'b0, "decode");
    cycles++;
    if (!legal) begin
      trap_tail(2'd1);
      trapped = 1;
      return;
    end
    cur_op2 = sel;
    e = '0;
    e.op2_sel = sel;
    e.pc_we = br;
    e.pc_jump = br && bt;
    step(rb(), rb(), bt, e, 1'b0, "exec");
    cycles++;
    done = br;
    if (!done && (ld || st)) begin
      for (int c = 0; c < TO; c++) begin
        e = '0;
        e.op2_sel = sel;
        e.dmem_req = 1'b1;
        e.dmem_we = st;
        e.pc_we = st && (c == dd);
        step(rb(), c == dd, rb(), e, 1'b0, "mem");
        cycles++;
        if (c == dd) break;
      end
      if (dd >= TO) begin
        trap_tail(2'd3);
        trapped = 1;
        return;
      end
      done = st;
    end
    if (!done) begin
      e = '0;
      e.op2_sel = sel;
      e.rf_we = 1'b1;
      e.pc_we = 1'b1;
      e.wb_mem = ld;
      e.pc_jump = jmp;
      step(rb(), rb(), rb(), e, 1'b0, "wb");
      cycles++;
    end
    chk("pc_we_once", 32'(pcwe_cnt), 32'd1);
  endtask

  initial begin
    int cyc;
    bit tr;
    outv_t e;
    logic [6:0] op;
    int di, dd;
    legal_ops = '{OPC_OP, OPC_BR, OPC_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_JAL, OPC_LUI, OPC_AUIPC};
    rst_n = 1'b0;
    opcode = '0;
    branch_taken = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    cur_op2 = RS2;
    pcwe_cnt = 0;
    @(posedge clk);
    #1;
    reset_dut();

    do_instr(OPC_IMM, 2, 0, 1'b0, cyc, tr);
    chk("addi_cycles", 32'(cyc), 32'd6);
    do_instr(OPC_LOAD,  0, 0, 1'b0, cyc, tr);
    do_instr(OPC_STORE, 0, 0, 1'b0, cyc, tr);
    do_instr(OPC_JAL,   0, 0, 1'b0, cyc, tr);
    do_instr(OPC_LUI,   0, 0, 1'b0, cyc, tr);
    do_instr(OPC_BR,    0, 0, 1'b1, cyc, tr);
    do_instr(OPC_BR,    0, 0, 1'b0, cyc, tr);
    do_instr(OPC_JALR,  1, 0, 1'b0, cyc, tr);
    do_instr(OPC_AUIPC, 0, 0, 1'b0, cyc, tr);
    do_instr(OPC_OP,    0, 0, 1'b0, cyc, tr);

    do_instr(7'b0000000, 0, 0, 1'b0, cyc, tr);
    chk("illegal_trapped", 32'(tr), 32'd1);
    reset_dut();

    do_instr(OPC_LOAD, 0, TO, 1'b0, cyc, tr);
    chk("dmem_timeout_trapped", 32'(tr), 32'd1);
    reset_dut();
    do_instr(OPC_LOAD, 0, TO - 1, 1'b0, cyc, tr);
    chk("dmem_ack_at_limit_cycles", 32'(cyc), 32'd8);
    do_instr(OPC_IMM, TO, 0, 1'b0, cyc, tr);
    chk("imem_timeout_trapped", 32'(tr), 32'd1);
    reset_dut();

    // Reset pulsed while a store sits in MEM waiting for its ack.
    opcode = OPC_STORE;
    pcwe_cnt = 0;
    e = '0; e.op2_sel = cur_op2; e.imem_req = 1'b1; e.ir_we = 1'b1;
    step(1'b1, 1'b0, 1'b0, e, 1'b0, "sw_fetch");
    e = '0; e.op2_sel = cur_op2;
    step(1'b0, 1'b0, 1'b0, e, 1'b0, "sw_decode");
    e = '0; e.op2_sel = IMS;
    step(1'b0, 1'b0, 1'b0, e, 1'b0, "sw_exec");
    e = '0; e.op2_sel = IMS; e.dmem_req = 1'b1; e.dmem_we = 1'b1;
    step(1'b0, 1'b0, 1'b0, e, 1'b0, "sw_mem");
    #1;
    chk("pre_reset_dmem_req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_mem_reset_dmem_req", 32'(dmem_req), 32'd0);
    chk("mid_mem_reset_dmem_we", 32'(dmem_we), 32'd0);
    @(posedge clk);
    #1;
    reset_dut();
    do_instr(OPC_IMM, 0, 0, 1'b0, cyc, tr);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 15) == 0) op = 7'($urandom_range(0, 127));
      else op = legal_ops[$urandom_range(0, 8)];
      di = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, TO - 1);
      dd = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
      do_instr(op, di, dd, rb(), cyc, tr);
      if (tr) reset_dut();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
